mem_line_server: RTL and testbench

MEM_LINE_SERVER -- requirements
Module: mem_line_server

---
 rtl/mem_line_server_pkg.sv | 15 +
 rtl/mem_line_array.sv | 30 +++
 rtl/mem_line_server.sv | 164 ++++++++++++++++
 tb/tb_mem_line_server.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_server_pkg.sv
// Shared sizing for the memory line server.
// MEM_ADDRESS_LEN   : byte address width on the fill and writeback ports
// DCACHE_LINE_WIDTH : cache line width in bits
// MEM_LATENCY_DEF   : default cycles from request acceptance to completion
// MEM_NLINES_DEF    : default number of lines held in the backing store
// CNT_W             : latency counter width (covers latencies 1..15)
package mem_line_server_pkg;

    localparam int unsigned MEM_ADDRESS_LEN   = 32;
    localparam int unsigned DCACHE_LINE_WIDTH = 128;
    localparam int unsigned MEM_LATENCY_DEF   = 5;
    localparam int unsigned MEM_NLINES_DEF    = 256;
    localparam int unsigned CNT_W             = 4;

endpackage : mem_line_server_pkg

// File: rtl/mem_line_array.sv
// Single-port line storage: synchronous write, combinational read.
// clk   : write clock
// we    : write enable, commits wdata to line addr at posedge
// addr  : line index shared by the read and write paths
// wdata : line to write
// rdata : contents of line addr (combinational)
module mem_line_array
    import mem_line_server_pkg::*;
#(
    parameter int unsigned NLINES = MEM_NLINES_DEF
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(NLINES)-1:0]     addr,
    input  logic [DCACHE_LINE_WIDTH-1:0]  wdata,
    output logic [DCACHE_LINE_WIDTH-1:0]  rdata
);

    // Storage powers up as all-zero lines; reset never touches it.
    logic [DCACHE_LINE_WIDTH-1:0] lines_q [NLINES] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            lines_q[addr] <= wdata;
        end
    end

    assign rdata = lines_q[addr];

endmodule : mem_line_array

// File: rtl/mem_line_server.sv
// Fixed-latency backing memory for a data cache: serves line fills and
// accepts dirty-line writebacks, writebacks taking priority.
// clk, reset : posedge clock, synchronous active-high reset
// req        : fill request level, held until data_rdy
// req_addr   : fill byte address (low 4 bits ignored)
// wb_valid   : writeback level, held until wb_ack
// wb_addr    : writeback byte address (low 4 bits ignored)
// wb_data    : evicted line contents
// fill_data  : requested line, valid from data_rdy until the next fill lands
// data_rdy   : one-cycle fill completion pulse
// wb_ack     : one-cycle writeback commit pulse
// busy       : high whenever the server is not idle
module mem_line_server
    import mem_line_server_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int unsigned MEM_NLINES  = MEM_NLINES_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req,
    input  logic [MEM_ADDRESS_LEN-1:0]    req_addr,
    input  logic                          wb_valid,
    input  logic [MEM_ADDRESS_LEN-1:0]    wb_addr,
    input  logic [DCACHE_LINE_WIDTH-1:0]  wb_data,
    output logic [DCACHE_LINE_WIDTH-1:0]  fill_data,
    output logic                          data_rdy,
    output logic                          wb_ack,
    output logic                          busy
);

    localparam int unsigned IDX_W = $clog2(MEM_NLINES);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_RD,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [DCACHE_LINE_WIDTH-1:0]   wline_q, wline_d;
    logic [DCACHE_LINE_WIDTH-1:0]   fill_q, fill_d;
    logic                           data_rdy_q, data_rdy_d;
    logic                           wb_ack_q, wb_ack_d;
    logic                           busy_q, busy_d;
    logic                           mem_we_c;
    logic [DCACHE_LINE_WIDTH-1:0]   mem_rdata_c;
    logic [IDX_W-1:0]               req_idx_c, wb_idx_c;
    logic                           unused_addr_c;

    // Line index drops the byte offset; upper address bits alias.
    assign req_idx_c     = req_addr[4 +: IDX_W];
    assign wb_idx_c      = wb_addr[4 +: IDX_W];
    assign unused_addr_c = ^{req_addr, wb_addr};

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wline_d    = wline_q;
        fill_d     = fill_q;
        data_rdy_d = 1'b0;
        wb_ack_d   = 1'b0;
        mem_we_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wb_valid) begin
                    state_d = S_WB;
                    idx_d   = wb_idx_c;
                    wline_d = wb_data;
                    cnt_d   = LAT_LOAD;
                end else if (req) begin
                    state_d = S_RD;
                    idx_d   = req_idx_c;
                    cnt_d   = LAT_LOAD;
                end
            end
            S_WB: begin
                if (cnt_q == '0) begin
                    mem_we_c = 1'b1;
                    wb_ack_d = 1'b1;
                    // A fill waiting behind the writeback goes straight to RD.
                    if (req) begin
                        state_d = S_RD;
                        idx_d   = req_idx_c;
                        cnt_d   = LAT_LOAD;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    fill_d  = mem_rdata_c;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                // data_rdy is registered, so the cache sees it one cycle
                // after fill_data has settled.
                data_rdy_d = 1'b1;
                state_d    = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wline_q    <= '0;
            fill_q     <= '0;
            data_rdy_q <= 1'b0;
            wb_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wline_q    <= wline_d;
            fill_q     <= fill_d;
            data_rdy_q <= data_rdy_d;
            wb_ack_q   <= wb_ack_d;
            busy_q     <= busy_d;
        end
    end

    // Reset in the commit cycle discards the writeback.
    mem_line_array #(
        .NLINES (MEM_NLINES)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_c & ~reset),
        .addr  (idx_q),
        .wdata (wline_q),
        .rdata (mem_rdata_c)
    );

    assign fill_data = fill_q;
    assign data_rdy  = data_rdy_q;
    assign wb_ack    = wb_ack_q;
    assign busy      = busy_q;

endmodule : mem_line_server

// File: tb/tb_mem_line_server.sv
module tb_mem_line_server;

    localparam int L0 = 5;
    localparam int L1 = 1;

    typedef struct packed {
        logic         is_rd;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic         req0, wbv0, rdy0, ack0, busy0;
    logic [31:0]  ra0, wa0;
    logic [127:0] wd0, fd0;
    logic         req1, wbv1, rdy1, ack1, busy1;
    logic [31:0]  ra1, wa1;
    logic [127:0] wd1, fd1;

    int total = 0;
    int bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    mem_line_server #(.MEM_LATENCY(L0), .MEM_NLINES(256)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .req_addr(ra0),
        .wb_valid(wbv0), .wb_addr(wa0), .wb_data(wd0),
        .fill_data(fd0), .data_rdy(rdy0), .wb_ack(ack0), .busy(busy0)
    );

    mem_line_server #(.MEM_LATENCY(L1), .MEM_NLINES(256)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .req_addr(ra1),
        .wb_valid(wbv1), .wb_addr(wa1), .wb_data(wd1),
        .fill_data(fd1), .data_rdy(rdy1), .wb_ack(ack1), .busy(busy1)
    );

    // Monitors: every pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (ack0) begin
            total++;
            if (q0.size() == 0) begin
                bad++; $display("FAIL mon0_ack: got unexpected wb_ack, expected none");
            end else begin
                e0 = q0.pop_front();
                if (e0.is_rd) begin bad++; $display("FAIL mon0_order: got wb_ack, expected data_rdy"); end
            end
        end
        if (rdy0) begin
            total++;
            if (q0.size() == 0) begin
                bad++; $display("FAIL mon0_rdy: got unexpected data_rdy fill=%h", fd0);
            end else begin
                e0 = q0.pop_front();
                if (!e0.is_rd) begin bad++; $display("FAIL mon0_order: got data_rdy, expected wb_ack"); end
                else if (fd0 !== e0.data) begin bad++; $display("FAIL mon0_fill: got %h expected %h", fd0, e0.data); end
            end
        end
    end

    always @(negedge clk) begin
        if (ack1) begin
            total++;
            if (q1.size() == 0) begin
                bad++; $display("FAIL mon1_ack: got unexpected wb_ack, expected none");
            end else begin
                e1 = q1.pop_front();
                if (e1.is_rd) begin bad++; $display("FAIL mon1_order: got wb_ack, expected data_rdy"); end
            end
        end
        if (rdy1) begin
            total++;
            if (q1.size() == 0) begin
                bad++; $display("FAIL mon1_rdy: got unexpected data_rdy fill=%h", fd1);
            end else begin
                e1 = q1.pop_front();
                if (!e1.is_rd) begin bad++; $display("FAIL mon1_order: got data_rdy, expected wb_ack"); end
                else if (fd1 !== e1.data) begin bad++; $display("FAIL mon1_fill: got %h expected %h", fd1, e1.data); end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input logic is_rd, input logic [127:0] d);
        exp_t e;
        e.is_rd = is_rd;
        e.data  = d;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic set_req(input int sel, input logic v, input logic [31:0] a);
        if (sel == 0) begin req0 = v; ra0 = a; end else begin req1 = v; ra1 = a; end
    endtask

    task automatic set_wb(input int sel, input logic v, input logic [31:0] a, input logic [127:0] d);
        if (sel == 0) begin wbv0 = v; wa0 = a; wd0 = d; end else begin wbv1 = v; wa1 = a; wd1 = d; end
    endtask

    // Waits for a pulse; lat counts cycles after the accepting edge.
    task automatic wait_pulse(input int sel, input logic rd, output int lat, output int busy_low);
        logic hit;
        lat = -1;
        busy_low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel == 0) hit = rd ? rdy0 : ack0; else hit = rd ? rdy1 : ack1;
            if (((sel == 0) ? busy0 : busy1) !== 1'b1) busy_low++;
            if (hit) begin lat = i; break; end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL timeout: no %s pulse on dut%0d within 40 cycles", rd ? "data_rdy" : "wb_ack", sel);
        end
    endtask

    task automatic do_write(input int sel, input logic [31:0] a, input logic [127:0] d, input string name);
        int lat, bl;
        push(sel, 1'b0, d);
        set_wb(sel, 1'b1, a, d);
        wait_pulse(sel, 1'b0, lat, bl);
        set_wb(sel, 1'b0, 32'h0, 128'h0);
        check({name, "_lat"}, 128'(lat), 128'((sel == 0) ? L0 : L1));
        repeat (2) @(negedge clk);
    endtask

    task automatic do_read(input int sel, input logic [31:0] a, input logic [127:0] d, input string name);
        int lat, bl;
        push(sel, 1'b1, d);
        set_req(sel, 1'b1, a);
        wait_pulse(sel, 1'b1, lat, bl);
        set_req(sel, 1'b0, 32'h0);
        check({name, "_lat"}, 128'(lat), 128'(((sel == 0) ? L0 : L1) + 1));
        check({name, "_busy"}, 128'(bl), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    logic [31:0]  tbl_addr [3];
    logic [127:0] tbl_data [3];
    int lat, bl, pulses;
    logic seen_ack;

    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, 32'h0); set_wb(0, 1'b0, 32'h0, 128'h0);
        set_req(1, 1'b0, 32'h0); set_wb(1, 1'b0, 32'h0, 128'h0);
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy0), 128'(0));
        check("rst_rdy", 128'(rdy0), 128'(0));
        check("rst_ack", 128'(ack0), 128'(0));
        check("rst_fill", fd0, 128'h0);
        check("rst_busy1", 128'(busy1), 128'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Unwritten line reads as zero.
        do_read(0, 32'h0000_0010, 128'h0, "rd_init");

        // Writeback then read of the same line.
        do_write(0, 32'h0000_0020, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, "wb20");
        do_read(0, 32'h0000_0020, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, "rd20");

        // Writeback and fill to 0x30 raised together: ack first, then data.
        push(0, 1'b0, 128'h0);
        push(0, 1'b1, 128'h3030_1111_2222_3333_4444_5555_6666_7777);
        set_wb(0, 1'b1, 32'h30, 128'h3030_1111_2222_3333_4444_5555_6666_7777);
        set_req(0, 1'b1, 32'h30);
        seen_ack = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack0) begin seen_ack = 1'b1; set_wb(0, 1'b0, 32'h0, 128'h0); end
            if (rdy0) begin lat = i; break; end
        end
        set_req(0, 1'b0, 32'h0);
        check("both_ack_first", 128'(seen_ack), 128'(1));
        check("both_done", 128'(lat >= 0), 128'(1));
        repeat (2) @(negedge clk);

        // Distinct lines including the last index and an aliased address.
        tbl_addr[0] = 32'h0000_0100; tbl_data[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        tbl_addr[1] = 32'h0000_02A0; tbl_data[1] = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0001;
        tbl_addr[2] = 32'h0000_0FF0; tbl_data[2] = 128'h8000_0000_0000_0000_0000_0000_0000_00FF;
        for (int i = 0; i < 3; i++) do_write(0, tbl_addr[i], tbl_data[i], "wb_tbl");
        for (int i = 0; i < 3; i++) do_read(0, tbl_addr[i], tbl_data[i], "rd_tbl");
        do_read(0, 32'h0000_1FF0, tbl_data[2], "rd_alias_ff");
        do_read(0, 32'h0000_0027, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, "rd_offset");

        // Reset two cycles into a writeback to 0x40 discards it.
        set_wb(0, 1'b1, 32'h40, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        set_wb(0, 1'b0, 32'h0, 128'h0);
        set_req(0, 1'b1, 32'h20);
        @(negedge clk);
        check("rstwb_busy", 128'(busy0), 128'(0));
        check("rstwb_ack", 128'(ack0), 128'(0));
        reset = 1'b0;
        set_req(0, 1'b0, 32'h0);
        repeat (8) @(negedge clk);
        do_read(0, 32'h0000_0040, 128'h0, "rd40_after_rst");

        // Reset mid-fill suppresses data_rdy and clears fill_data.
        set_req(0, 1'b1, 32'h20);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        set_req(0, 1'b0, 32'h0);
        reset = 1'b0;
        check("rstrd_fill", fd0, 128'h0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy0) pulses++;
        end
        check("rstrd_no_rdy", 128'(pulses), 128'(0));

        // req held across data_rdy: one pulse, then a fresh fill after
        // DRAIN; address change and req drop mid-fill are ignored.
        push(0, 1'b1, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        push(0, 1'b1, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        set_req(0, 1'b1, 32'h20);
        wait_pulse(0, 1'b1, lat, bl);
        check("hold_lat", 128'(lat), 128'(L0 + 1));
        @(negedge clk);
        check("hold_idle_busy", 128'(busy0), 128'(0));
        check("hold_idle_rdy", 128'(rdy0), 128'(0));
        @(negedge clk);
        check("hold_refill_busy", 128'(busy0), 128'(1));
        set_req(0, 1'b0, 32'h100);
        wait_pulse(0, 1'b1, lat, bl);
        check("hold_refill_lat", 128'(lat), 128'(L0));
        repeat (3) @(negedge clk);

        // Latency-1 build with aliasing.
        do_write(1, 32'h0000_0010, 128'h1111_2222_3333_4444_5555_6666_7777_8888, "l1_wb");
        do_read(1, 32'h0000_1010, 128'h1111_2222_3333_4444_5555_6666_7777_8888, "l1_rd_alias");
        do_read(1, 32'h0000_0020, 128'h0, "l1_rd_zero");

        repeat (4) @(negedge clk);
        check("q0_empty", 128'(q0.size()), 128'(0));
        check("q1_empty", 128'(q1.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_line_server
